// File: rtl/zoom_config_sequencer_pkg.sv
// Shared types and default dimensions for the zoom configuration sequencer.
// The tuple layout {zoom_in, alg, k} matches the request/commit registers.
package zoom_config_sequencer_pkg;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int VGA_W = 640;
  localparam int VGA_H = 480;

  typedef enum logic [1:0] {
    K_1X = 2'd0,
    K_2X = 2'd1,
    K_4X = 2'd2,
    K_8X = 2'd3
  } k_lvl_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FLUSH      = 2'd2,
    APPLY      = 2'd3
  } state_t;

  typedef struct packed {
    logic   zoom_in;
    logic   alg;
    k_lvl_t k;
  } cfg_t;

  typedef struct packed {
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] ho;
    logic [9:0] vo;
    logic       crop;
  } geom_t;

endpackage

// File: rtl/zoom_config_sequencer_stabilizer.sv
// Holds the last sampled request tuple and counts how long it has been steady.
// stable_o rises once the same value has been seen DEBOUNCE_CYCLES times.
module zoom_config_sequencer_stabilizer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] cand_o,
  output logic         stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sample_i != cand_q) begin
      cand_d = sample_i;
      cnt_d  = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand_o   = cand_q;
  assign stable_o = (cnt_q == CMAX);

endmodule

// File: rtl/zoom_config_sequencer.sv
// Frame-synchronous zoom configuration commit: debounce, wait for frame end,
// flush pipelines, then load cfg and display geometry in one cycle.
module zoom_config_sequencer
  import zoom_config_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH       = IMG_W,
  parameter int IMG_HEIGHT      = IMG_H,
  parameter int VGA_WIDTH       = VGA_W,
  parameter int VGA_HEIGHT      = VGA_H,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FLUSH_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zoom_in_out_req,
  input  logic       algorithm_req,
  input  logic [1:0] k_req,
  input  logic       frame_end,
  output logic       cfg_zoom_in_out,
  output logic       cfg_algorithm,
  output logic [1:0] cfg_k,
  output logic [9:0] display_width,
  output logic [9:0] display_height,
  output logic [9:0] h_offset,
  output logic [9:0] v_offset,
  output logic       crop_8x,
  output logic       pipe_flush,
  output logic       cfg_busy,
  output logic       cfg_update
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FONE  = FW'(1);
  localparam logic [9:0] IW = 10'(IMG_WIDTH);
  localparam logic [9:0] IH = 10'(IMG_HEIGHT);
  localparam logic [9:0] VW = 10'(VGA_WIDTH);
  localparam logic [9:0] VH = 10'(VGA_HEIGHT);
  localparam geom_t GEOM_RST = '{
    w: IW, h: IH,
    ho: 10'((VGA_WIDTH - IMG_WIDTH) / 2),
    vo: 10'((VGA_HEIGHT - IMG_HEIGHT) / 2),
    crop: 1'b0
  };

  state_t        state_q, state_d;
  cfg_t          pend_q, pend_d;
  cfg_t          cfg_q;
  cfg_t          cand;
  logic [3:0]    cand_raw;
  logic          stable;
  logic [FW-1:0] fcnt_q, fcnt_d;
  geom_t         geom_q, geom_d;
  logic          flush_q, busy_q, upd_q;

  zoom_config_sequencer_stabilizer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .W(4)
  ) u_stab (
    .clk     (clk),
    .reset   (reset),
    .sample_i({zoom_in_out_req, algorithm_req, k_req}),
    .cand_o  (cand_raw),
    .stable_o(stable)
  );

  assign cand = cfg_t'(cand_raw);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (stable && (cand != cfg_q)) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!stable) begin
          state_d = IDLE;
        end else if (frame_end) begin
          pend_d  = cand;
          fcnt_d  = FLOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt_q == FONE) state_d = APPLY;
        else fcnt_d = fcnt_q - 1'b1;
      end
      APPLY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // 8x zoom-in never forms IMG<<3; it maps straight to a full-screen crop.
  always_comb begin
    geom_d = '0;
    if (pend_q.zoom_in && pend_q.k == K_8X) begin
      geom_d.w    = VW;
      geom_d.h    = VH;
      geom_d.crop = 1'b1;
    end else if (pend_q.k == K_1X) begin
      geom_d.w = IW;
      geom_d.h = IH;
    end else if (pend_q.zoom_in) begin
      geom_d.w = IW << pend_q.k;
      geom_d.h = IH << pend_q.k;
    end else begin
      geom_d.w = IW >> pend_q.k;
      geom_d.h = IH >> pend_q.k;
    end
    geom_d.ho = (VW - geom_d.w) >> 1;
    geom_d.vo = (VH - geom_d.h) >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      fcnt_q  <= '0;
      cfg_q   <= '0;
      geom_q  <= GEOM_RST;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      flush_q <= (state_d == FLUSH);
      busy_q  <= (state_d != IDLE);
      upd_q   <= (state_d == APPLY);
      if (state_q == APPLY) begin
        cfg_q  <= pend_q;
        geom_q <= geom_d;
      end
    end
  end

  assign cfg_zoom_in_out = cfg_q.zoom_in;
  assign cfg_algorithm   = cfg_q.alg;
  assign cfg_k           = cfg_q.k;
  assign display_width   = geom_q.w;
  assign display_height  = geom_q.h;
  assign h_offset        = geom_q.ho;
  assign v_offset        = geom_q.vo;
  assign crop_8x         = geom_q.crop;
  assign pipe_flush      = flush_q;
  assign cfg_busy        = busy_q;
  assign cfg_update      = upd_q;

endmodule

// File: tb/tb_zoom_config_sequencer.sv
// Directed bench for zoom_config_sequencer with short debounce/flush windows.
// Table of commits plus hand sequences for abort, reset and overlap cases.
module tb_zoom_config_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zr = 1'b0, ar = 1'b0, fe = 1'b0;
  logic [1:0] kr = 2'd0;
  logic       cz, ca, crop, flush, busy, upd;
  logic [1:0] ck;
  logic [9:0] dw, dh, ho, vo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  zoom_config_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .FLUSH_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .zoom_in_out_req(zr),
    .algorithm_req  (ar),
    .k_req          (kr),
    .frame_end      (fe),
    .cfg_zoom_in_out(cz),
    .cfg_algorithm  (ca),
    .cfg_k          (ck),
    .display_width  (dw),
    .display_height (dh),
    .h_offset       (ho),
    .v_offset       (vo),
    .crop_8x        (crop),
    .pipe_flush     (flush),
    .cfg_busy       (busy),
    .cfg_update     (upd)
  );

  typedef struct {
    logic       z;
    logic       a;
    logic [1:0] k;
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] ho;
    logic [9:0] vo;
    logic       crop;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_out(string t, logic z, logic a, logic [1:0] k,
                         logic [9:0] w, logic [9:0] h,
                         logic [9:0] eho, logic [9:0] evo, logic ec);
    chk({t, ".zoom"}, 32'(cz), 32'(z));
    chk({t, ".alg"}, 32'(ca), 32'(a));
    chk({t, ".k"}, 32'(ck), 32'(k));
    chk({t, ".w"}, 32'(dw), 32'(w));
    chk({t, ".h"}, 32'(dh), 32'(h));
    chk({t, ".ho"}, 32'(ho), 32'(eho));
    chk({t, ".vo"}, 32'(vo), 32'(evo));
    chk({t, ".crop"}, 32'(crop), 32'(ec));
  endtask

  task automatic set_req(logic z, logic a, logic [1:0] k);
    zr = z;
    ar = a;
    kr = k;
  endtask

  // Pulse frame_end, then watch 12 cycles; wu is the width seen during update.
  task automatic commit(output int nf, output int nu, output logic [9:0] wu);
    nf = 0;
    nu = 0;
    wu = '0;
    fe = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      fe = 1'b0;
      if (flush) nf++;
      if (upd) begin
        nu++;
        wu = dw;
      end
    end
  endtask

  initial begin
    int nf, nu, sb, sf, su;
    logic [9:0] wu, prev_w;

    vecs[0] = '{1'b1, 1'b0, 2'd1, 10'd320, 10'd240, 10'd160, 10'd120, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'd3, 10'd640, 10'd480, 10'd0,   10'd0,   1'b1};
    vecs[2] = '{1'b0, 1'b0, 2'd3, 10'd20,  10'd15,  10'd310, 10'd232, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd2, 10'd40,  10'd30,  10'd300, 10'd225, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 10'd640, 10'd480, 10'd0,   10'd0,   1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 10'd160, 10'd120, 10'd240, 10'd180, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 10'd80,  10'd60,  10'd280, 10'd210, 1'b0};

    repeat (3) tick();
    chk_out("rst", 0, 0, 0, 160, 120, 240, 180, 0);
    chk("rst.flush", 32'(flush), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.upd", 32'(upd), 0);
    reset = 1'b0;

    sb = 0; sf = 0; su = 0;
    for (int i = 0; i < 30; i++) begin
      fe = (i % 5 == 2);
      tick();
      if (busy) sb++;
      if (flush) sf++;
      if (upd) su++;
    end
    fe = 1'b0;
    chk("t1.busy_seen", 32'(sb), 0);
    chk("t1.flush_seen", 32'(sf), 0);
    chk("t1.upd_seen", 32'(su), 0);
    chk_out("t1", 0, 0, 0, 160, 120, 240, 180, 0);

    prev_w = 10'd160;
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].z, vecs[i].a, vecs[i].k);
      repeat (6) tick();
      chk($sformatf("v%0d.wait_busy", i), 32'(busy), 1);
      commit(nf, nu, wu);
      chk($sformatf("v%0d.nflush", i), 32'(nf), 4);
      chk($sformatf("v%0d.nupd", i), 32'(nu), 1);
      chk($sformatf("v%0d.w_at_upd", i), 32'(wu), 32'(prev_w));
      chk_out($sformatf("v%0d", i), vecs[i].z, vecs[i].a, vecs[i].k,
              vecs[i].w, vecs[i].h, vecs[i].ho, vecs[i].vo, vecs[i].crop);
      chk($sformatf("v%0d.idle", i), 32'(busy), 0);
      prev_w = vecs[i].w;
    end

    sb = 0; sf = 0; su = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) kr = (kr == 2'd2) ? 2'd3 : 2'd2;
      fe = (i % 5 == 0);
      tick();
      if (busy) sb++;
      if (flush) sf++;
      if (upd) su++;
    end
    fe = 1'b0;
    chk("t5.busy_seen", 32'(sb), 0);
    chk("t5.flush_seen", 32'(sf), 0);
    chk("t5.upd_seen", 32'(su), 0);
    chk("t5.k_kept", 32'(ck), 1);

    set_req(1, 1, 0);
    repeat (6) tick();
    chk("t5.wait_busy", 32'(busy), 1);
    set_req(0, 0, 1);
    tick();
    tick();
    chk("t5.abort_idle", 32'(busy), 0);
    su = 0;
    for (int i = 0; i < 12; i++) begin
      fe = (i % 4 == 1);
      tick();
      if (upd) su++;
    end
    fe = 1'b0;
    chk("t5.abort_upd", 32'(su), 0);
    chk_out("t5.abort", 0, 0, 1, 80, 60, 280, 210, 0);

    set_req(1, 0, 1);
    repeat (6) tick();
    fe = 1'b1;
    tick();
    fe = 1'b0;
    tick();
    chk("t6.flush2", 32'(flush), 1);
    reset = 1'b1;
    set_req(0, 0, 0);
    tick();
    chk("t6.rst_flush", 32'(flush), 0);
    chk("t6.rst_busy", 32'(busy), 0);
    chk("t6.rst_upd", 32'(upd), 0);
    chk_out("t6.rst", 0, 0, 0, 160, 120, 240, 180, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    set_req(1, 0, 1);
    repeat (6) tick();
    chk("t6b.wait_busy", 32'(busy), 1);
    fe = 1'b1;
    tick();
    fe = 1'b0;
    nf = flush ? 1 : 0;
    nu = 0;
    set_req(0, 1, 2);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (flush) nf++;
      if (upd) nu++;
    end
    chk("t6b.nflush_a", 32'(nf), 4);
    chk("t6b.nupd_a", 32'(nu), 1);
    chk_out("t6b.a", 1, 0, 1, 320, 240, 160, 120, 0);
    chk("t6b.pending_b", 32'(busy), 1);
    commit(nf, nu, wu);
    chk("t6b.nflush_b", 32'(nf), 4);
    chk("t6b.nupd_b", 32'(nu), 1);
    chk_out("t6b.b", 0, 1, 2, 40, 30, 300, 225, 0);
    chk("t6b.idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
